// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: state encoding and default watchdog limit shared by the uart_tx_arbiter slice
package uart_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT_DONE = 2'd2} arb_state_t;
    localparam int DEF_TIMEOUT_CYC = 200000;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first valid index scanning ptr, ptr+1, ... mod N
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);
    always_comb begin
        winner = '0;
        any    = |valid;
        // walk from the far end so the entry nearest ptr is written last and wins
        for (int i = N - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (valid[idx]) winner = W'(idx);
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX core among N_REQ byte requesters with a watchdog.
// Define UART_ARB_LOCK_EN to add req_last, which holds the grant on one requester until its last byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int IDW         = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   req_last,
`endif
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_newd,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic [IDW-1:0]     grant_id,
    output logic               busy,
    output logic               timeout_err
);
    localparam int WDW = $clog2(TIMEOUT_CYC) + 1;

    arb_state_t     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic           any;
    logic [WDW-1:0] wdog;
    logic           done_q;
    logic           done_rise;
    logic           expire;
    logic [N_REQ-1:0] cand;

`ifdef UART_ARB_LOCK_EN
    logic locked;
    assign cand = locked ? (req_valid & (N_REQ'(1) << grant_id)) : req_valid;
`else
    assign cand = req_valid;
`endif

    assign done_rise = tx_done & ~done_q;
    assign expire    = wdog == WDW'(TIMEOUT_CYC - 1);
    assign busy      = state != IDLE;

    rr_pick #(.N(N_REQ), .W(IDW)) u_pick (
        .valid  (cand),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= '0;
            tx_newd     <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            ptr         <= '0;
            wdog        <= '0;
            done_q      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            locked      <= 1'b0;
`endif
        end else begin
            done_q    <= tx_done;
            req_ready <= '0;
            case (state)
                IDLE: if (any) begin
                    state     <= LAUNCH;
                    tx_newd   <= 1'b1;
                    tx_data   <= req_data[8*winner +: 8];
                    grant_id  <= winner;
                    req_ready <= N_REQ'(1) << winner;
                    ptr       <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    wdog      <= '0;
`ifdef UART_ARB_LOCK_EN
                    locked    <= ~req_last[winner];
`endif
                end
                default: begin
                    wdog <= wdog + 1'b1;
                    // completion outranks a watchdog expiry in the same cycle
                    if (done_rise) begin
                        state   <= IDLE;
                        tx_newd <= 1'b0;
                    end else if (expire) begin
                        state       <= IDLE;
                        tx_newd     <= 1'b0;
                        timeout_err <= 1'b1;
`ifdef UART_ARB_LOCK_EN
                        locked      <= 1'b0;
`endif
                    end else if (state == LAUNCH && tx_busy) begin
                        state   <= WAIT_DONE;
                        tx_newd <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized producers and TX core against a transaction-level round-robin reference
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 50;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
`ifdef UART_ARB_LOCK_EN
    logic [N-1:0]   req_last = '1;
`endif
    logic [N-1:0]   req_ready;
    logic           tx_newd;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [IW-1:0]  grant_id;
    logic           busy;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_last    (req_last),
`endif
        .req_ready   (req_ready),
        .tx_newd     (tx_newd),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int cnt [N];
    int core_mode, core_phase, core_cnt, lat_max, dur_max;
    logic [7:0] core_byte;
    bit cb_ok, arrive_en, drop_en, last_rand;

    logic [N-1:0]  m_ready;
    logic [IW-1:0] m_gid;
    logic [7:0]    m_data;
    logic m_busy, m_launch, m_terr, m_locked, d_last;
    int   m_ptr, m_age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ready = '0; m_gid = '0; m_data = '0; m_busy = 0; m_launch = 0;
        m_terr = 0; m_locked = 0; d_last = 0; m_ptr = 0; m_age = 0;
    endtask

    // one transaction-level update per clock edge, from the inputs the DUT sampled
    task automatic model_edge();
        logic [N-1:0] v;
        logic rise;
        int w;
        m_ready = '0;
        rise = tx_done && !d_last;
        if (rst) begin
            model_reset();
            return;
        end
        d_last = tx_done;
        v = req_valid;
`ifdef UART_ARB_LOCK_EN
        if (m_locked) v = req_valid & (N'(1) << m_gid);
`endif
        if (!m_busy) begin
            w = pick(v, m_ptr);
            if (w >= 0) begin
                m_ready[w] = 1'b1;
                m_gid = IW'(w);
                m_data = req_data[8*w +: 8];
                m_ptr = (w + 1) % N;
                m_busy = 1; m_launch = 1; m_age = 0;
`ifdef UART_ARB_LOCK_EN
                m_locked = !req_last[w];
`endif
            end
        end else begin
            if (rise) begin
                m_busy = 0; m_launch = 0;
            end else if (m_age == TO - 1) begin
                m_busy = 0; m_launch = 0; m_terr = 1; m_locked = 0;
            end else if (m_launch && tx_busy) m_launch = 0;
            m_age++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] || (drop_en && req_valid[i] && $urandom_range(49) == 0
                                 && !(m_locked && m_gid == IW'(i)))) begin
                cnt[i]--;
                req_data[8*i +: 8] = 8'($urandom);
`ifdef UART_ARB_LOCK_EN
                req_last[i] = last_rand ? 1'($urandom) : 1'b1;
`endif
            end
            if (arrive_en && cnt[i] < 3 && $urandom_range(19) == 0) cnt[i]++;
            if (m_locked && m_gid == IW'(i) && cnt[i] == 0) cnt[i] = 1;
            req_valid[i] = cnt[i] > 0;
        end
        tx_done = 1'b0;
        if (core_mode == 1) tx_busy = 1'b0;
        else if (core_mode == 2) tx_busy = 1'b1;
        else if (core_phase == 2) begin
            core_cnt--;
            if (core_cnt == 0) begin
                tx_busy = 1'b0; tx_done = 1'b1; core_phase = 0;
                if (cb_ok) chk("tx_data_stable", tx_data, core_byte);
            end
        end else if (core_phase == 1) begin
            if (core_cnt == 0) begin
                tx_busy = 1'b1; core_phase = 2; core_byte = tx_data; cb_ok = 1;
                core_cnt = $urandom_range(dur_max, 1);
            end else core_cnt--;
        end else if (tx_newd) begin
            core_phase = 1;
            core_cnt = $urandom_range(lat_max);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("req_ready", req_ready, m_ready);
        chk("grant_id", grant_id, m_gid);
        chk("tx_data", tx_data, m_data);
        chk("tx_newd", tx_newd, m_launch);
        chk("busy", busy, m_busy);
        chk("timeout_err", timeout_err, m_terr);
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (cnt[i] > 0) return 1;
        return 0;
    endfunction

    task automatic load();
        for (int i = 0; i < N; i++) req_valid[i] = cnt[i] > 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((busy || pending()) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cb_ok = 0;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        core_mode = 0; core_phase = 0; core_cnt = 0; core_byte = '0;
        lat_max = 2; dur_max = 8; cb_ok = 0;
        arrive_en = 0; drop_en = 0; last_rand = 0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_ready", req_ready, 0);

        req_data[7:0] = 8'hA5;
        cnt[0] = 1;
        load();
        drain("drain_single", 200);

        pulse_rst();
        for (int i = 0; i < N; i++) cnt[i] = 2;
        load();
        drain("drain_all4", 600);

        cnt[1] = 1;
        load();
        for (int n = 0; n < 40 && !(busy && !tx_newd); n++) step();
        cnt[2] = 1;
        load();
        drain("drain_late", 200);

        core_mode = 1;
        cnt[0] = 1; cnt[3] = 1;
        load();
        drain("drain_to_silent", 300);
        chk("timeout_sticky", timeout_err, 1);
        core_mode = 2;
        cnt[1] = 1;
        load();
        drain("drain_to_stuck", 200);
        core_mode = 0; core_phase = 0; tx_busy = 1'b0;
        cnt[2] = 1;
        load();
        drain("drain_after_to", 200);
        chk("timeout_still", timeout_err, 1);

        lat_max = 0; dur_max = 12;
        cnt[1] = 1;
        load();
        for (int n = 0; n < 40 && !(busy && !tx_newd); n++) step();
        pulse_rst();
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_newd", tx_newd, 0);
        for (int i = 0; i < N; i++) cnt[i] = 1;
        load();
        drain("drain_post_rst", 400);

        lat_max = 3; dur_max = 15;
        arrive_en = 1; drop_en = 1; last_rand = 1;
        repeat (3000) step();
        arrive_en = 0; drop_en = 0; last_rand = 0;
        drain("drain_random", 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8-bit UART transmitter core among N_REQ byte requesters using round-robin arbitration.
- Latches the winner's byte and launches it into the core with a start/busy/done handshake.
- Waits for completion, with a watchdog timeout, before it grants again.
- Sits between the system-side producers (console, debug, status reporters) and the UART TX core clocked from clk.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 200000, clk cycles allowed from launch to tx_done before abort.
- IDW, $clog2(N_REQ), width of grant_id.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte pending; must stay high with stable data until its req_ready pulse.
- req_data  in  8*N_REQ  byte of requester i at [8i+7:8i].
- req_ready  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- tx_newd  out  1  start request to TX core.
- tx_data  out  8  byte to TX core; stable from launch through tx_done.
- tx_busy  in  1  core is transmitting (start accepted).
- tx_done  in  1  core finished byte (pulse or level, rising edge used).
- grant_id  out  IDW  index of current/last granted requester.
- busy  out  1  arbiter not in IDLE.
- timeout_err  out  1  sticky: a transfer timed out.

Behaviour:
- Reset values: state=IDLE, req_ready=0, tx_newd=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, rr pointer=0, watchdog=0.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - If any req_valid is high, pick the first valid index scanning ptr, ptr+1, … mod N_REQ.
  - At the next edge: latch req_data[winner] into tx_data, set grant_id=winner, pulse req_ready[winner] for exactly that one cycle, set ptr=(winner+1) mod N_REQ, go to LAUNCH.
  - Latency: valid sampled at edge k gives ready high in cycle k+1 and tx_newd high in cycle k+1.
- LAUNCH: tx_newd=1. On tx_busy=1, go to WAIT_DONE with tx_newd=0 at the next edge.
- WAIT_DONE: on a tx_done rising edge (registered previous value), go to IDLE. The next grant may be sampled in the same IDLE cycle.
- Watchdog:
  - Cleared on entering LAUNCH; increments every cycle in LAUNCH/WAIT_DONE.
  - When it equals TIMEOUT_CYC-1: set timeout_err=1, tx_newd=0, go to IDLE. The byte is dropped and ptr stays advanced.
- req_valid changes while not in IDLE are ignored. No requester is re-granted until the current byte completes.
- A requester dropping valid before its ready pulse is allowed; it simply loses its turn.
- tx_done arriving while in LAUNCH, without tx_busy first, is treated as completion → IDLE.
- Simultaneous watchdog expiry and tx_done: completion wins, timeout_err not set.
- rst mid-transfer: immediate return to reset values at the edge. The core is not notified; it finishes its byte on its own.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Defined:
  - Adds input req_last [N_REQ].
  - Once requester i is granted a byte with req_last[i]=0, the arbiter locks to i. Subsequent grants go only to i, other valids are ignored, and ptr does not advance, until a byte with req_last[i]=1 is accepted.
  - ptr then becomes i+1. A timeout also releases the lock.
- Undefined: no req_last port; every byte is arbitrated independently.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE/LAUNCH/WAIT_DONE as 2-bit), default TIMEOUT_CYC constant.
- Sub-module rr_pick (combinational round-robin priority pick: valid vector + ptr → winner index + any flag), instantiated once.

Test Plan:
- Single requester: N_REQ=4, req_valid=0001, data 8'hA5 → one ready[0] pulse, tx_newd held until tx_busy, tx_data=A5 stable to tx_done, busy falls after done.
- All four valid, ptr=0, back-to-back → grant order 0,1,2,3, then 0 again. Each requester gets exactly one ready pulse per round; grant_id matches.
- Requester 2 valid while a transfer for 1 is in WAIT_DONE → no ready[2] until tx_done; next grant 2 within 1 cycle of IDLE.
- Core never asserts tx_done, TIMEOUT_CYC=50 → timeout_err=1 on the 50th cycle after launch, state IDLE, next pending requester served; timeout_err stays 1 until rst.
- rst asserted in WAIT_DONE → next cycle all outputs at reset values, ptr=0.
- UART_ARB_LOCK_EN: req 1 sends 3 bytes with last=0,0,1 while req 0 and 3 are valid → bytes of 1 are sent consecutively, then grant to 3 (ptr=2 scan), then 0.
